// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//   Shares one external ALU between two requesters. A three-state FSM
//   (IDLE -> EXEC -> RESP) grants one request at a time. When both requesters
//   are valid, a round-robin pointer decides the winner. The granted operands
//   and opcode are latched and driven to the ALU for one EXEC cycle. The
//   result and flags are then captured and held in RESP until the consumer
//   takes them.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req0_valid/ready/a/b/op    requester 0 handshake and payload
//   req1_valid/ready/a/b/op    requester 1 handshake and payload
//   alu_a, alu_b, alu_gin      operands and control code to the shared ALU
//   alu_sum, alu_zout          ALU result and zero indication
//   rsp_valid, rsp_ready       response handshake
//   rsp_id                     requester that owns the response
//   rsp_result                 captured result
//   rsp_zero, rsp_neg, rsp_err zero flag, sign bit, illegal-opcode flag
//   busy                       high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter bit FIRST_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_op,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_op,

    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_gin,
    input  logic [31:0] alu_sum,
    input  logic        alu_zout,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_neg,
    output logic        rsp_err,

    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic        r_ptr;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [3:0]  r_op;
    logic        r_id;

    logic [31:0] r_result;
    logic        r_zero;
    logic        r_neg;
    logic        r_err;
    logic        r_rspId;

    logic        w_idle;
    logic        w_grantValid;
    logic        w_grantId;
    logic        w_accept;
    logic        w_opLegal;

    assign w_idle = (r_state == IDLE);

    // Grant selection. A lone valid requester wins outright, and a tie goes
    // to the round-robin pointer. The grant is only meaningful in IDLE.
    always_comb begin
        w_grantValid = req0_valid | req1_valid;
        w_grantId    = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grantId = r_ptr;
        end else if (req1_valid) begin
            w_grantId = 1'b1;
        end
    end

    // Ready is gated with reset so that nothing appears accepted while the
    // block is held in reset.
    assign req0_ready = w_idle & w_grantValid & ~w_grantId & ~reset;
    assign req1_ready = w_idle & w_grantValid &  w_grantId & ~reset;
    assign w_accept   = req0_ready | req1_ready;

    // Opcode legality check on the latched opcode.
    always_comb begin
        w_opLegal = 1'b0;
        case (r_op)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
            4'b1000, 4'b1001, 4'b1010, 4'b1111: w_opLegal = 1'b1;
            default:                            w_opLegal = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. The FSM only moves around the fixed ring.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = EXEC;
            EXEC:    w_nextState = RESP;
            RESP:    if (rsp_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Request capture. The pointer moves to the other requester only when a
    // request is actually accepted. A requester that withdraws therefore
    // keeps its turn.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= FIRST_PRIO;
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= '0;
            r_id  <= 1'b0;
        end else if (w_accept) begin
            r_ptr <= ~w_grantId;
            r_a   <= w_grantId ? req1_a  : req0_a;
            r_b   <= w_grantId ? req1_b  : req0_b;
            r_op  <= w_grantId ? req1_op : req0_op;
            r_id  <= w_grantId;
        end
    end

    // Response capture at the end of EXEC. An illegal opcode gives a forced
    // zero result with the error flag set, and the ALU output is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
            r_err    <= 1'b0;
            r_rspId  <= 1'b0;
        end else if (r_state == EXEC) begin
            r_rspId <= r_id;
            if (w_opLegal) begin
                r_result <= alu_sum;
                r_zero   <= alu_zout;
                r_neg    <= alu_sum[31];
                r_err    <= 1'b0;
            end else begin
                r_result <= '0;
                r_zero   <= 1'b1;
                r_neg    <= 1'b0;
                r_err    <= 1'b1;
            end
        end
    end

    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_gin    = w_opLegal ? r_op : 4'b0000;

    assign rsp_valid  = (r_state == RESP);
    assign rsp_id     = r_rspId;
    assign rsp_result = r_result;
    assign rsp_zero   = r_zero;
    assign rsp_neg    = r_neg;
    assign rsp_err    = r_err;

    assign busy       = ~w_idle;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Purpose:
//   Directed testbench for alu_arbiter with FIRST_PRIO = 0. A small
//   behavioural ALU answers the arbiter's ALU port. Every check compares a
//   DUT output against a hand-computed value.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] alu_a, alu_b, alu_sum;
    logic [3:0]  alu_gin;
    logic        alu_zout;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_neg, rsp_err;
    logic        busy;

    int numChecks = 0;
    int numBad    = 0;

    int grantIds[4];
    int grantCycles[4];
    int numGrants;

    alu_arbiter #(.FIRST_PRIO(1'b0)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_gin    (alu_gin),
        .alu_sum    (alu_sum),
        .alu_zout   (alu_zout),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_neg    (rsp_neg),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural shared ALU that sits behind the arbiter.
    always_comb begin
        alu_sum = '0;
        case (alu_gin)
            4'b0000: alu_sum = alu_a & alu_b;
            4'b0001: alu_sum = alu_a | alu_b;
            4'b0010: alu_sum = alu_a + alu_b;
            4'b0110: alu_sum = alu_a - alu_b;
            4'b0111: alu_sum = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'b1000: alu_sum = alu_a ^ alu_b;
            4'b1001: alu_sum = alu_a << alu_b[4:0];
            4'b1010: alu_sum = alu_a >> alu_b[4:0];
            4'b1111: alu_sum = ~(alu_a | alu_b);
            default: alu_sum = '0;
        endcase
        alu_zout = (alu_sum == 32'd0);
    end

    // Counts one comparison and reports it if the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numBad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives both request ports, then waits for the combinational outputs to settle.
    task automatic applyStimulus(input logic v0, input logic [3:0] op0,
                                 input logic [31:0] a0, input logic [31:0] b0,
                                 input logic v1, input logic [3:0] op1,
                                 input logic [31:0] a1, input logic [31:0] b1);
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        #1;
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        rsp_ready = 1'b1;

        // Hold reset with both requesters valid. Nothing may be granted.
        applyStimulus(1'b1, 4'b0010, 32'd9, 32'd9, 1'b1, 4'b0010, 32'd9, 32'd9);
        waitCycle();
        checkOutput("rst_ready0", req0_ready, 0);
        checkOutput("rst_ready1", req1_ready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_alu_a", alu_a, 0);
        checkOutput("rst_alu_gin", alu_gin, 0);
        checkOutput("rst_result", rsp_result, 0);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        waitCycle();
        reset = 1'b0;
        waitCycle();

        // req0 adds 5 + 7.
        applyStimulus(1'b1, 4'b0010, 32'd5, 32'd7, 1'b0, 4'd0, 32'd0, 32'd0);
        checkOutput("add_ready0", req0_ready, 1);
        checkOutput("add_ready1", req1_ready, 0);
        waitCycle();
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        checkOutput("add_exec_busy", busy, 1);
        checkOutput("add_exec_alu_a", alu_a, 5);
        checkOutput("add_exec_alu_b", alu_b, 7);
        checkOutput("add_exec_gin", alu_gin, 4'b0010);
        checkOutput("add_exec_rsp_valid", rsp_valid, 0);
        waitCycle();
        checkOutput("add_rsp_valid", rsp_valid, 1);
        checkOutput("add_result", rsp_result, 12);
        checkOutput("add_zero", rsp_zero, 0);
        checkOutput("add_neg", rsp_neg, 0);
        checkOutput("add_err", rsp_err, 0);
        checkOutput("add_id", rsp_id, 0);
        waitCycle();
        checkOutput("add_done_valid", rsp_valid, 0);
        checkOutput("add_done_busy", busy, 0);

        // req1 subtracts 0x80000000 - 0x80000000.
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'b0110, 32'h8000_0000, 32'h8000_0000);
        checkOutput("sub_ready1", req1_ready, 1);
        waitCycle();
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        checkOutput("sub_exec_gin", alu_gin, 4'b0110);
        waitCycle();
        checkOutput("sub_rsp_valid", rsp_valid, 1);
        checkOutput("sub_result", rsp_result, 0);
        checkOutput("sub_zero", rsp_zero, 1);
        checkOutput("sub_neg", rsp_neg, 0);
        checkOutput("sub_id", rsp_id, 1);
        waitCycle();

        // Both requesters stay valid, so grants must alternate 0,1,0,1 three cycles apart.
        numGrants = 0;
        applyStimulus(1'b1, 4'b0010, 32'd1, 32'd1, 1'b1, 4'b0001, 32'd2, 32'd4);
        for (int c = 0; c < 12; c++) begin
            if (c > 0) waitCycle();
            checkOutput("rr_onehot", {31'd0, req0_ready & req1_ready}, 0);
            if ((req0_ready || req1_ready) && numGrants < 4) begin
                grantIds[numGrants]    = req1_ready ? 1 : 0;
                grantCycles[numGrants] = c;
                numGrants++;
            end
        end
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        waitCycle();
        checkOutput("rr_count", numGrants, 4);
        for (int i = 0; i < numGrants; i++) begin
            checkOutput("rr_grant_id", grantIds[i], i % 2);
            if (i > 0) checkOutput("rr_spacing", grantCycles[i] - grantCycles[i-1], 3);
        end

        // An illegal opcode, then the response is held for 5 cycles while req1 waits.
        rsp_ready = 1'b0;
        applyStimulus(1'b1, 4'b0011, 32'd3, 32'd5, 1'b0, 4'd0, 32'd0, 32'd0);
        checkOutput("ill_ready0", req0_ready, 1);
        waitCycle();
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'b0001, 32'h0000_00F0, 32'h0000_000F);
        checkOutput("ill_exec_gin", alu_gin, 4'b0000);
        waitCycle();
        for (int c = 0; c < 5; c++) begin
            checkOutput("hold_rsp_valid", rsp_valid, 1);
            checkOutput("hold_result", rsp_result, 0);
            checkOutput("hold_err", rsp_err, 1);
            checkOutput("hold_id", rsp_id, 0);
            checkOutput("hold_busy", busy, 1);
            checkOutput("hold_ready0", req0_ready, 0);
            checkOutput("hold_ready1", req1_ready, 0);
            waitCycle();
        end
        rsp_ready = 1'b1;
        #1;
        checkOutput("drain_ready1", req1_ready, 0);
        waitCycle();
        checkOutput("resume_busy", busy, 0);
        checkOutput("resume_ready1", req1_ready, 1);
        waitCycle();
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        waitCycle();
        checkOutput("or_result", rsp_result, 32'h0000_00FF);
        checkOutput("or_id", rsp_id, 1);
        checkOutput("or_err", rsp_err, 0);
        waitCycle();

        // Accept req0, which moves the pointer to 1. Then reset during EXEC.
        applyStimulus(1'b1, 4'b0010, 32'd1, 32'd2, 1'b0, 4'd0, 32'd0, 32'd0);
        checkOutput("rx_ready0", req0_ready, 1);
        waitCycle();
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        checkOutput("rx_exec_busy", busy, 1);
        reset = 1'b1;
        #1;
        checkOutput("rx_busy", busy, 0);
        checkOutput("rx_rsp_valid", rsp_valid, 0);
        checkOutput("rx_alu_a", alu_a, 0);
        checkOutput("rx_alu_b", alu_b, 0);
        checkOutput("rx_result", rsp_result, 0);
        checkOutput("rx_id", rsp_id, 0);
        waitCycle();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            waitCycle();
            checkOutput("rx_no_rsp", rsp_valid, 0);
        end
        applyStimulus(1'b1, 4'b0010, 32'd10, 32'd20, 1'b1, 4'b0010, 32'd30, 32'd40);
        checkOutput("rx_prio_ready0", req0_ready, 1);
        checkOutput("rx_prio_ready1", req1_ready, 0);
        waitCycle();
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        waitCycle();
        checkOutput("rx_after_result", rsp_result, 30);
        checkOutput("rx_after_id", rsp_id, 0);
        waitCycle();

        $display("test done: total=%0d bad=%0d", numChecks, numBad);
        $finish;
    end

endmodule
